// File: rtl/note_sequencer_pkg.sv
// rtl/note_sequencer_pkg.sv - shared types and defaults for the note sequencer
package note_sequencer_pkg;

  localparam int DEF_DEPTH     = 8;
  localparam int DEF_DUR_W     = 16;
  localparam int DEF_GAP_TICKS = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } seq_state_t;

  // Field order matches the packed FIFO word built in the top level.
  typedef struct packed {
    logic [7:0]           note;
    logic [DEF_DUR_W-1:0] dur;
    logic [7:0]           amp;
    logic [1:0]           wave;
  } note_evt_t;

endpackage

// File: rtl/note_fifo.sv
// rtl/note_fifo.sv - single-clock note-event FIFO with count and registered ready
module note_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      count,
  output logic             ready
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_n;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && ready;
  assign do_pop  = pop && (count != '0);
  assign rdata   = mem[rd_ptr];

  always_comb begin
    count_n = count;
    if (do_push && !do_pop)
      count_n = count + (AW+1)'(1);
    else if (do_pop && !do_push)
      count_n = count - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear)
      mem[wr_ptr] <= wdata;
  end

  // ready is registered from the next count so it never depends on push in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b1;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b1;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count_n;
      ready <= (count_n < (AW+1)'(DEPTH));
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - queued note player: FIFO, play/gap FSM and registered player drive
module note_sequencer
  import note_sequencer_pkg::*;
#(
  parameter int DEPTH     = DEF_DEPTH,
  parameter int DUR_W     = DEF_DUR_W,
  parameter int GAP_TICKS = DEF_GAP_TICKS,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_tick,
  input  logic             enable,
  input  logic             abort,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [7:0]       wr_note,
  input  logic [DUR_W-1:0] wr_dur,
  input  logic [7:0]       wr_amp,
  input  logic [1:0]       wr_wave,
  output logic [7:0]       midi_data,
  output logic             midi_valid,
  output logic [7:0]       amplitude,
  output logic [1:0]       waveform_select,
  output logic             busy,
  output logic             note_done,
  output logic [AW:0]      fifo_count
);

  localparam int EW = 18 + DUR_W;

  seq_state_t       state, state_n;
  logic [DUR_W-1:0] cnt, cnt_n;
  logic [EW-1:0]    head;
  logic             fifo_pop;
  logic             start;
  logic             valid_n;
  logic             done_n;

  logic [7:0]       head_note;
  logic [DUR_W-1:0] head_dur;
  logic [7:0]       head_amp;
  logic [1:0]       head_wave;

  assign head_note = head[EW-1 -: 8];
  assign head_dur  = head[DUR_W+9 : 10];
  assign head_amp  = head[9:2];
  assign head_wave = head[1:0];

  note_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_valid && !abort),
    .pop   (fifo_pop),
    .clear (abort),
    .wdata ({wr_note, wr_dur, wr_amp, wr_wave}),
    .rdata (head),
    .count (fifo_count),
    .ready (wr_ready)
  );

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    fifo_pop = 1'b0;
    start    = 1'b0;
    valid_n  = midi_valid;
    done_n   = 1'b0;
    if (abort) begin
      state_n = IDLE;
      cnt_n   = '0;
      valid_n = 1'b0;
    end else begin
      unique case (state)
        IDLE: start = enable && (fifo_count != '0);
        PLAY: begin
          if (sample_tick) begin
            if (cnt <= DUR_W'(1)) begin
              state_n = GAP;
              cnt_n   = DUR_W'(GAP_TICKS);
              valid_n = 1'b0;
              done_n  = 1'b1;
            end else begin
              cnt_n = cnt - DUR_W'(1);
            end
          end
        end
        GAP: begin
          if (cnt == '0) begin
            if (enable && (fifo_count != '0))
              start = 1'b1;
            else
              state_n = IDLE;
          end else if (sample_tick) begin
            cnt_n = cnt - DUR_W'(1);
          end
        end
        default: state_n = IDLE;
      endcase
      // A zero duration still plays for one tick.
      if (start) begin
        fifo_pop = 1'b1;
        state_n  = PLAY;
        cnt_n    = (head_dur == '0) ? DUR_W'(1) : head_dur;
        valid_n  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      midi_valid      <= 1'b0;
      note_done       <= 1'b0;
      busy            <= 1'b0;
      midi_data       <= '0;
      amplitude       <= '0;
      waveform_select <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      midi_valid <= valid_n;
      note_done  <= done_n;
      busy       <= (state_n != IDLE);
      if (start) begin
        midi_data       <= head_note;
        amplitude       <= head_amp;
        waveform_select <= head_wave;
      end
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - directed self-checking bench for note_sequencer
module tb_note_sequencer;

  localparam int DUR_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             sample_tick;
  logic             enable;
  logic             abort;
  logic             wr_valid;
  logic             wr_ready;
  logic [7:0]       wr_note;
  logic [DUR_W-1:0] wr_dur;
  logic [7:0]       wr_amp;
  logic [1:0]       wr_wave;
  logic [7:0]       midi_data;
  logic             midi_valid;
  logic [7:0]       amplitude;
  logic [1:0]       waveform_select;
  logic             busy;
  logic             note_done;
  logic [3:0]       fifo_count;

  note_sequencer #(.DEPTH(8), .DUR_W(DUR_W), .GAP_TICKS(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .sample_tick     (sample_tick),
    .enable          (enable),
    .abort           (abort),
    .wr_valid        (wr_valid),
    .wr_ready        (wr_ready),
    .wr_note         (wr_note),
    .wr_dur          (wr_dur),
    .wr_amp          (wr_amp),
    .wr_wave         (wr_wave),
    .midi_data       (midi_data),
    .midi_valid      (midi_valid),
    .amplitude       (amplitude),
    .waveform_select (waveform_select),
    .busy            (busy),
    .note_done       (note_done),
    .fifo_count      (fifo_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One sample_tick every 4 clocks.
  int tick_phase = 0;
  initial begin
    sample_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tick_phase  = (tick_phase + 1) % 4;
      sample_tick = (tick_phase == 0);
    end
  end

  int         play_ticks = 0;
  int         gap_ticks  = 0;
  int         done_cnt   = 0;
  int         play_q[$];
  int         gap_q[$];
  logic [7:0] note_q[$];
  logic [7:0] amp_q[$];
  logic [1:0] wave_q[$];
  logic       prev_valid = 1'b0;

  always @(negedge clk) begin
    if (midi_valid && !prev_valid) begin
      note_q.push_back(midi_data);
      amp_q.push_back(amplitude);
      wave_q.push_back(waveform_select);
      gap_q.push_back(gap_ticks);
      gap_ticks = 0;
    end
    if (!midi_valid && prev_valid) begin
      play_q.push_back(play_ticks);
      play_ticks = 0;
    end
    if (midi_valid && sample_tick) play_ticks++;
    if (busy && !midi_valid && sample_tick) gap_ticks++;
    if (!busy) gap_ticks = 0;
    if (note_done) done_cnt++;
    prev_valid = midi_valid;
  end

  task automatic clear_mon();
    play_q.delete(); gap_q.delete(); note_q.delete(); amp_q.delete(); wave_q.delete();
    play_ticks = 0; gap_ticks = 0; done_cnt = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] n, input logic [15:0] d, input logic [7:0] a, input logic [1:0] w);
    wr_note = n; wr_dur = d; wr_amp = a; wr_wave = w; wr_valid = 1'b1;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit done = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      step();
      @(negedge clk);
      if (!busy && !midi_valid && fifo_count == 0) done = 1;
    end
    check({tag, "_idle_timeout"}, done, 1);
  endtask

  task automatic wait_valid(input string tag);
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      step();
      @(negedge clk);
      if (midi_valid) seen = 1;
    end
    check({tag, "_valid_timeout"}, seen, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; enable = 1'b0; abort = 1'b0; wr_valid = 1'b0;
    wr_note = '0; wr_dur = '0; wr_amp = '0; wr_wave = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_midi_valid", midi_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_midi_data", midi_data, 0);
    check("rst_amplitude", amplitude, 0);
    check("rst_wave", waveform_select, 0);
    check("rst_note_done", note_done, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_wr_ready", wr_ready, 1);

    // single note, one-cycle pop latency
    clear_mon();
    enable = 1'b1;
    push(8'd60, 16'd4, 8'hFF, 2'd0);
    @(negedge clk);
    check("one_count_after_push", fifo_count, 1);
    check("one_valid_before_pop", midi_valid, 0);
    step();
    @(negedge clk);
    check("one_valid_after_pop", midi_valid, 1);
    check("one_midi_data", midi_data, 60);
    check("one_amplitude", amplitude, 8'hFF);
    check("one_count_after_pop", fifo_count, 0);
    wait_idle("one");
    check("one_play_ticks", play_q.size() > 0 ? play_q[0] : -1, 4);
    check("one_note_done", done_cnt, 1);

    // two notes with gap
    clear_mon();
    enable = 1'b0;
    push(8'd60, 16'd4, 8'hFF, 2'd0);
    push(8'd62, 16'd4, 8'h80, 2'd2);
    enable = 1'b1;
    wait_idle("two");
    check("two_notes", note_q.size(), 2);
    check("two_first_note", note_q.size() > 0 ? note_q[0] : 8'd0, 60);
    check("two_second_note", note_q.size() > 1 ? note_q[1] : 8'd0, 62);
    check("two_second_amp", amp_q.size() > 1 ? amp_q[1] : 8'd0, 8'h80);
    check("two_second_wave", wave_q.size() > 1 ? wave_q[1] : 2'd0, 2);
    check("two_first_ticks", play_q.size() > 0 ? play_q[0] : -1, 4);
    check("two_second_ticks", play_q.size() > 1 ? play_q[1] : -1, 4);
    check("two_gap_ticks", gap_q.size() > 1 ? gap_q[1] : -1, 2);
    check("two_note_done", done_cnt, 2);

    // fill to full with enable low, ninth push dropped
    clear_mon();
    enable = 1'b0;
    for (int i = 0; i < 9; i++) begin
      wr_note = 8'(40 + i); wr_dur = 16'd1; wr_amp = 8'(i); wr_wave = 2'(i);
      wr_valid = 1'b1;
      step();
      if (i == 7) begin
        @(negedge clk);
        check("full_wr_ready", wr_ready, 0);
        check("full_count", fifo_count, 8);
      end
    end
    wr_valid = 1'b0;
    @(negedge clk);
    check("full_count_after_ninth", fifo_count, 8);
    enable = 1'b1;
    wait_idle("full");
    check("full_notes_played", note_q.size(), 8);
    check("full_last_note", note_q.size() > 7 ? note_q[7] : 8'd0, 47);
    check("full_note_done", done_cnt, 8);

    // zero duration plays one tick
    clear_mon();
    push(8'd70, 16'd0, 8'h10, 2'd1);
    wait_idle("zero");
    check("zero_play_ticks", play_q.size() > 0 ? play_q[0] : -1, 1);
    check("zero_note_done", done_cnt, 1);

    // abort during play with three queued, push in abort cycle dropped
    clear_mon();
    enable = 1'b0;
    for (int i = 0; i < 4; i++) push(8'(50 + i), 16'd8, 8'h40, 2'd3);
    enable = 1'b1;
    wait_valid("abort");
    check("abort_queued", fifo_count, 3);
    repeat (6) step();
    abort = 1'b1;
    wr_note = 8'd99; wr_dur = 16'd3; wr_valid = 1'b1;
    step();
    abort = 1'b0; wr_valid = 1'b0;
    @(negedge clk);
    check("abort_midi_valid", midi_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_fifo_count", fifo_count, 0);
    check("abort_note_done_now", note_done, 0);
    repeat (30) step();
    @(negedge clk);
    check("abort_no_note_done", done_cnt, 0);
    check("abort_stays_idle", busy, 0);

    // async reset mid-note
    clear_mon();
    enable = 1'b0;
    push(8'd72, 16'd8, 8'h55, 2'd2);
    push(8'd74, 16'd8, 8'h55, 2'd2);
    enable = 1'b1;
    wait_valid("arst");
    #1 rst = 1'b1;
    #1;
    check("arst_midi_valid", midi_valid, 0);
    check("arst_midi_data", midi_data, 0);
    check("arst_amplitude", amplitude, 0);
    check("arst_wave", waveform_select, 0);
    check("arst_busy", busy, 0);
    check("arst_fifo_count", fifo_count, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("arst_wr_ready", wr_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 Parameter DEPTH, 8, note-event FIFO entries (power of two).
REQ-002 Parameter DUR_W, 16, duration counter width, in sample ticks.
REQ-003 Parameter GAP_TICKS, 16, silent ticks inserted after each note (0 allowed).
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 sample_tick  in  1  one-cycle strobe per audio sample period.
REQ-007 enable  in  1  permits starting new notes.
REQ-008 abort  in  1  one-cycle request: stop current note, flush FIFO.
REQ-009 wr_valid / wr_ready  in / out  1 / 1  event push handshake.
REQ-010 wr_note  in  8  MIDI note number.
REQ-011 wr_dur  in  DUR_W  note length in sample ticks.
REQ-012 wr_amp  in  8  amplitude; wr_wave  in  2  waveform select.
REQ-013 midi_data  out  8, midi_valid  out  1, amplitude  out  8, waveform_select  out  2  player drive.
REQ-014 busy  out  1  state not IDLE; note_done  out  1  one-cycle pulse at note end.
REQ-015 fifo_count  out  log2(DEPTH)+1  stored entries.

Function
REQ-016 FIFO accepts a push when wr_valid && wr_ready; wr_ready = (fifo_count < DEPTH).
REQ-017 Push while full is ignored; FIFO contents unchanged.
REQ-018 Push and pop in same cycle while not full: both occur, fifo_count unchanged.
REQ-019 States: IDLE, PLAY, GAP.
REQ-020 IDLE: if enable && fifo_count>0, pop head, register fields, enter PLAY; midi_valid=1 from the next cycle (1-cycle latency).
REQ-021 PLAY: midi_data/amplitude/waveform_select hold popped entry; counter loads wr_dur (0 treated as 1); decrement on each sample_tick.
REQ-022 PLAY exits on the sample_tick that takes counter to 0: midi_valid=0 next cycle, note_done pulses one cycle, enter GAP.
REQ-023 GAP: midi_valid=0, midi_data holds last note; counter loads GAP_TICKS, decrements on sample_tick; GAP_TICKS=0 leaves GAP the following cycle.
REQ-024 GAP end: if enable && fifo_count>0, pop and enter PLAY (same rules as REQ-020); else IDLE.
REQ-025 enable deasserted during PLAY or GAP: current note and gap complete; no new pop.
REQ-026 abort (any state): next cycle state=IDLE, midi_valid=0, fifo_count=0, no note_done; push in abort cycle discarded.
REQ-027 abort has priority over push, pop and counter expiry in the same cycle.
REQ-028 sample_tick while IDLE has no effect; counters never wrap below 0.
REQ-029 All outputs registered.

Reset
REQ-030 On rst: state IDLE, FIFO empty, fifo_count=0, wr_ready=1 after release, midi_data=0, midi_valid=0, amplitude=0, waveform_select=0, busy=0, note_done=0.
REQ-031 rst mid-note forces midi_valid=0 immediately (asynchronously).

Structure
REQ-032 Shared package holds state enum, note-event struct (note 8, dur DUR_W, amp 8, wave 2), default parameter constants.
REQ-033 FIFO is one sub-module, note_fifo (synchronous, single clock, count output).
REQ-034 Top holds FSM, duration/gap counter, output registers only.

Verification
REQ-035 Push {60, dur 4, amp FF, wave 0}, enable=1, tick every 4 clk -> midi_valid=1 one cycle after pop, midi_data=60 for exactly 4 ticks, one note_done pulse.
REQ-036 Push 60 then 62, GAP_TICKS=2 -> 60 plays 4 ticks, midi_valid=0 for 2 ticks, then midi_data=62, amplitude/waveform from second entry.
REQ-037 Push 9 entries with enable=0 -> wr_ready=0 after 8th, fifo_count=8, 9th dropped; enable=1 plays exactly 8 notes.
REQ-038 abort during PLAY with 3 queued -> next cycle midi_valid=0, busy=0, fifo_count=0, no note_done.
REQ-039 Push wr_dur=0 -> note lasts exactly 1 tick.
REQ-040 rst asserted mid-PLAY between clock edges -> midi_valid=0 before next edge, all outputs at reset values.
